tt_um_instr_fetch: RTL

//  Instruction-fetch reader for the program-counter output: takes the word-aligned PC and reads

---
 rtl/tt_um_instr_fetch.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tt_um_instr_fetch.sv
// Instruction-fetch reader: latches the word-aligned PC on a request, reads
// BYTES consecutive bytes from a byte-wide ROM (each byte is given MEM_LAT
// wait cycles before sampling), then streams them out one byte per cycle
// with a valid strobe on uio_out[1].
//
// Handshake: there is no ready. A request (uio_in[0]) is only looked at in
// IDLE; once accepted, valid is asserted for exactly BYTES consecutive
// enabled cycles and the consumer must take every byte it sees while valid=1.
module tt_um_instr_fetch #(
    parameter int MEM_LAT = 1,
    parameter int BYTES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam logic [2:0] LAT    = 3'(MEM_LAT);
    localparam logic [1:0] LAST_B = 2'(BYTES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] base;
    logic [1:0] k;
    logic [2:0] w;
    logic [1:0] j;
    logic [7:0] fetch_buf [4];
    logic       valid;
    logic       req;
    logic       unused_in;

    assign req       = uio_in[0];
    // Bit 1 carries no meaning as an input; the PC low bits are never address bits.
    assign unused_in = uio_in[1];

    // Next-state decode; only transitions, no datapath.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = FETCH;
            FETCH:   if (w == LAT && k == LAST_B) state_next = PRESENT;
            PRESENT: if (j == LAST_B) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; ena low freezes everything so a resume is seamless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // Address, wait/byte counters and fetched bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= 8'h00;
            k    <= 2'd0;
            w    <= 3'd0;
            j    <= 2'd0;
            for (int i = 0; i < 4; i++) fetch_buf[i] <= 8'h00;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        base <= {uio_in[7:2], 2'b00};
                        k    <= 2'd0;
                        w    <= 3'd0;
                    end
                end
                FETCH: begin
                    if (w < LAT) begin
                        w <= w + 3'd1;
                    end else begin
                        fetch_buf[k] <= ui_in;
                        if (k < LAST_B) begin
                            k <= k + 2'd1;
                            w <= 3'd0;
                        end else begin
                            j <= 2'd0;
                        end
                    end
                end
                PRESENT: begin
                    if (j < LAST_B) j <= j + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output mux driven from registers only; nothing from inputs reaches the pins.
    always_comb begin
        uo_out = 8'h00;
        valid  = 1'b0;
        case (state)
            FETCH:   uo_out = base + {6'b0, k};
            PRESENT: begin
                uo_out = fetch_buf[j];
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

    assign uio_out = {6'b0, valid, 1'b0};
    assign uio_oe  = 8'b0000_0010;

endmodule
